// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg
// Shared definitions for the serial receive controller: FSM state encoding,
// data width of a frame and the default oversampling ratio.
// Optional feature macro used by the importing files: SERIAL_RX_PARITY_EN.

package serial_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int DATA_BITS      = 8;
    localparam int OVERSAMPLE_DEF = 16;

endpackage

// File: rtl/serial_rx_ctl_if.sv
// serial_rx_ctl_if
// Received-byte handshake bundle between serial_rx_ctl and its consumer.
//   Data      received byte
//   Valid     Data holds an unconsumed byte
//   Ready     consumer accepts Data on Valid && Ready
//   FrameErr  stop bit of the byte in Data sampled low
//   Overrun   a byte was overwritten before it was accepted
//   ParityErr even-parity check failed (only when SERIAL_RX_PARITY_EN)
// master: the controller side; slave: the consumer side.

interface serial_rx_ctl_if;
    import serial_rx_pkg::*;

    logic [DATA_BITS-1:0] Data;
    logic                 Valid;
    logic                 Ready;
    logic                 FrameErr;
    logic                 Overrun;
`ifdef SERIAL_RX_PARITY_EN
    logic                 ParityErr;
`endif

`ifdef SERIAL_RX_PARITY_EN
    modport master (output Data, Valid, FrameErr, Overrun, ParityErr, input Ready);
    modport slave  (input Data, Valid, FrameErr, Overrun, ParityErr, output Ready);
`else
    modport master (output Data, Valid, FrameErr, Overrun, input Ready);
    modport slave  (input Data, Valid, FrameErr, Overrun, output Ready);
`endif

endinterface

// File: rtl/serial_rx_sync.sv
// serial_rx_sync
// Two-flop synchronizer for an asynchronous single-bit input.
//   Clock   rising-edge clock
//   nReset  asynchronous active-low reset; both flops load RST_VAL
//   d       asynchronous input
//   q       synchronized output, two Clock cycles behind d

module serial_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic Clock,
    input  logic nReset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_rx_ctl.sv
// serial_rx_ctl
// Bit-timing and framing controller for an LSB-first serial line
// (start, 8 data bits, [parity,] stop). Drives an external 8-bit right-shift
// register at bit centres and captures its parallel output into a holding
// register presented on a valid/ready handshake.
// Optional feature: SERIAL_RX_PARITY_EN adds an even-parity bit and ParityErr.
//   Clock    rising-edge clock
//   nReset   asynchronous active-low reset
//   Tick     oversample strobe; all bit timing advances only on Tick
//   RxD      asynchronous serial input, idles high
//   ShiftIn  sampled data bit to the shift register
//   Enable   one-cycle shift enable per data bit
//   Q        parallel output of the shift register
//   rx_if    received-byte handshake (Data/Valid/Ready/FrameErr/Overrun[/ParityErr])
//
// state  | meaning
// IDLE   | line idle, waiting for a low sample on Tick
// START  | counting to the start-bit centre; high there means glitch
// DATA   | sampling 8 data bits at their centres, one Enable each
// PARITY | sampling the parity bit (SERIAL_RX_PARITY_EN only)
// STOP   | sampling the stop bit and loading the holding register

module serial_rx_ctl
    import serial_rx_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int CNT_W      = 4
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 Tick,
    input  logic                 RxD,
    output logic                 ShiftIn,
    output logic                 Enable,
    input  logic [DATA_BITS-1:0] Q,
    serial_rx_ctl_if.master      rx_if
);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    logic rx;

    rx_state_t            state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [2:0]           bitcnt, bitcnt_n;
    logic                 shift_n, en_n, load;

    logic [DATA_BITS-1:0] data_q, data_n;
    logic                 valid_q, valid_n;
    logic                 ferr_q, ferr_n;
    logic                 ovr_q, ovr_n;
`ifdef SERIAL_RX_PARITY_EN
    logic                 parity_bit, par_n;
    logic                 perr_q, perr_n;
`endif

    serial_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .Clock  (Clock),
        .nReset (nReset),
        .d      (RxD),
        .q      (rx)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            cnt        <= '0;
            bitcnt     <= '0;
            ShiftIn    <= 1'b0;
            Enable     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_bit <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bitcnt     <= bitcnt_n;
            ShiftIn    <= shift_n;
            Enable     <= en_n;
            data_q     <= data_n;
            valid_q    <= valid_n;
            ferr_q     <= ferr_n;
            ovr_q      <= ovr_n;
`ifdef SERIAL_RX_PARITY_EN
            parity_bit <= par_n;
            perr_q     <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bitcnt_n = bitcnt;
        shift_n  = ShiftIn;
        en_n     = 1'b0;
        load     = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_n    = parity_bit;
`endif

        if (Tick) begin
            case (state)
                IDLE: begin
                    if (!rx) begin
                        state_n = START;
                        cnt_n   = '0;
                    end
                end
                START: begin
                    if (cnt == CNT_MID) begin
                        cnt_n = '0;
                        if (!rx) begin
                            state_n  = DATA;
                            bitcnt_n = '0;
                        end else begin
                            state_n  = IDLE;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_END) begin
                        cnt_n    = '0;
                        shift_n  = rx;
                        en_n     = 1'b1;
                        bitcnt_n = bitcnt + 3'd1;
                        if (bitcnt == BIT_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
`ifdef SERIAL_RX_PARITY_EN
                    if (cnt == CNT_END) begin
                        cnt_n   = '0;
                        par_n   = rx;
                        state_n = STOP;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
`else
                    state_n = IDLE;
                    cnt_n   = '0;
`endif
                end
                STOP: begin
                    if (cnt == CNT_END) begin
                        cnt_n   = '0;
                        load    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end

        data_n  = data_q;
        valid_n = valid_q;
        ferr_n  = ferr_q;
        ovr_n   = ovr_q;
`ifdef SERIAL_RX_PARITY_EN
        perr_n  = perr_q;
`endif
        // A load beats a same-edge handshake; overrun only if the old byte
        // was still pending and not taken on this edge.
        if (load) begin
            data_n  = Q;
            ferr_n  = ~rx;
            valid_n = 1'b1;
            ovr_n   = valid_q & ~rx_if.Ready;
`ifdef SERIAL_RX_PARITY_EN
            perr_n  = (^Q) ^ parity_bit;
`endif
        end else if (valid_q && rx_if.Ready) begin
            valid_n = 1'b0;
            ovr_n   = 1'b0;
        end
    end

    assign rx_if.Data      = data_q;
    assign rx_if.Valid     = valid_q;
    assign rx_if.FrameErr  = ferr_q;
    assign rx_if.Overrun   = ovr_q;
`ifdef SERIAL_RX_PARITY_EN
    assign rx_if.ParityErr = perr_q;
`endif

endmodule

// File: tb/tb_serial_rx_ctl.sv
// tb_serial_rx_ctl
// Bench for serial_rx_ctl: drives serial frames, models the downstream
// right-shift register, and checks the received bytes, shift pulses,
// error flags and handshake against values derived from each frame.
// Honours SERIAL_RX_PARITY_EN in the same way as the design.

module tb_serial_rx_ctl;
    import serial_rx_pkg::*;

    localparam int OS = 16;

    logic       Clock = 1'b0;
    logic       nReset = 1'b0;
    logic       Tick = 1'b0;
    logic       RxD = 1'b1;
    logic       ShiftIn;
    logic       Enable;
    logic [7:0] q_sr;

    int vectors = 0;
    int miscompares = 0;

    serial_rx_ctl_if rx_if();

    serial_rx_ctl #(.OVERSAMPLE(OS), .CNT_W(4)) dut (
        .Clock   (Clock),
        .nReset  (nReset),
        .Tick    (Tick),
        .RxD     (RxD),
        .ShiftIn (ShiftIn),
        .Enable  (Enable),
        .Q       (q_sr),
        .rx_if   (rx_if.master)
    );

    always #5 Clock = ~Clock;

    // downstream 8-bit right-shift register: new bit enters at the MSB
    always @(posedge Clock or negedge nReset) begin
        if (!nReset) q_sr <= 8'h00;
        else if (Enable) q_sr <= {ShiftIn, q_sr[7:1]};
    end

    // monitor
    int         cyc = 0;
    int         en_cyc[$];
    logic       en_bits[$];
    int         val_cyc[$];
    logic [7:0] cap_data[$];
    logic       cap_ferr[$];
    logic       cap_perr[$];
    int         val_hi = 0;
    int         en_wide = 0;
    logic       prev_en = 1'b0;
    logic       prev_val = 1'b0;

    always @(posedge Clock) cyc = cyc + 1;

    always @(posedge Clock) begin
        #1;
        if (Enable) begin
            en_cyc.push_back(cyc);
            en_bits.push_back(ShiftIn);
            if (prev_en) en_wide++;
        end
        if (rx_if.Valid) val_hi++;
        if (rx_if.Valid && !prev_val) begin
            val_cyc.push_back(cyc);
            cap_data.push_back(rx_if.Data);
            cap_ferr.push_back(rx_if.FrameErr);
`ifdef SERIAL_RX_PARITY_EN
            cap_perr.push_back(rx_if.ParityErr);
`else
            cap_perr.push_back(1'b0);
`endif
        end
        prev_en  = Enable;
        prev_val = rx_if.Valid;
    end

    task automatic clear_mon();
        en_cyc.delete();
        en_bits.delete();
        val_cyc.delete();
        cap_data.delete();
        cap_ferr.delete();
        cap_perr.delete();
        val_hi  = 0;
        en_wide = 0;
    endtask

    // hold RxD at b for n Ticks; sparse mode gates Tick randomly
    task automatic tick_cycles(input logic b, input int n, input bit sparse);
        int k;
        k = 0;
        RxD = b;
        while (k < n) begin
            @(negedge Clock);
            Tick = sparse ? 1'($urandom_range(0, 1)) : 1'b1;
            if (Tick) k++;
        end
    endtask

    task automatic idle(input int n);
        tick_cycles(1'b1, n, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input bit sparse);
        tick_cycles(1'b0, OS, sparse);
        for (int i = 0; i < 8; i++) tick_cycles(d[i], OS, sparse);
`ifdef SERIAL_RX_PARITY_EN
        tick_cycles(par, OS, sparse);
`else
        if (par === 1'bz) tick_cycles(1'b1, 0, sparse);
`endif
        tick_cycles(stop, OS, sparse);
    endtask

    function automatic logic [7:0] bits_from(input int first);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 8; i++)
            if (first + i < en_bits.size()) v[i] = en_bits[first + i];
        return v;
    endfunction

    task automatic test_reset();
        nReset = 1'b0;
        Ready_drv(1'b0);
        repeat (3) @(negedge Clock);
        vectors++; if (ShiftIn !== 1'b0) begin miscompares++; $display("FAIL reset_shiftin got %b expected 0", ShiftIn); end
        vectors++; if (Enable !== 1'b0) begin miscompares++; $display("FAIL reset_enable got %b expected 0", Enable); end
        vectors++; if (rx_if.Data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h expected 00", rx_if.Data); end
        vectors++; if (rx_if.Valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b expected 0", rx_if.Valid); end
        vectors++; if (rx_if.FrameErr !== 1'b0) begin miscompares++; $display("FAIL reset_frameerr got %b expected 0", rx_if.FrameErr); end
        vectors++; if (rx_if.Overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b expected 0", rx_if.Overrun); end
`ifdef SERIAL_RX_PARITY_EN
        vectors++; if (rx_if.ParityErr !== 1'b0) begin miscompares++; $display("FAIL reset_parityerr got %b expected 0", rx_if.ParityErr); end
`endif
        nReset = 1'b1;
        idle(4);
    endtask

    task automatic Ready_drv(input logic r);
        rx_if.Ready = r;
    endtask

    task automatic test_basic();
        int c0;
        Ready_drv(1'b1);
        clear_mon();
        c0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        idle(4);
        vectors++;
        if (en_cyc.size() != 8) begin
            miscompares++; $display("FAIL basic_enable_count got %0d expected 8", en_cyc.size());
        end else begin
            vectors++; if (bits_from(0) !== 8'hA5) begin miscompares++; $display("FAIL basic_shiftin got %h expected a5", bits_from(0)); end
            vectors++; if (en_cyc[0] != c0 + 3 + OS/2 + OS) begin miscompares++; $display("FAIL basic_first_enable got %0d expected %0d", en_cyc[0] - c0, 3 + OS/2 + OS); end
            for (int i = 1; i < 8; i++) begin
                vectors++; if (en_cyc[i] - en_cyc[i-1] != OS) begin miscompares++; $display("FAIL basic_enable_spacing got %0d expected %0d", en_cyc[i] - en_cyc[i-1], OS); end
            end
        end
        vectors++;
        if (val_cyc.size() != 1) begin
            miscompares++; $display("FAIL basic_valid_count got %0d expected 1", val_cyc.size());
        end else begin
            vectors++; if (val_cyc[0] != c0 + 3 + 9*OS + OS/2) begin miscompares++; $display("FAIL basic_valid_time got %0d expected %0d", val_cyc[0] - c0, 3 + 9*OS + OS/2); end
            vectors++; if (cap_data[0] !== 8'hA5) begin miscompares++; $display("FAIL basic_data got %h expected a5", cap_data[0]); end
            vectors++; if (cap_ferr[0] !== 1'b0) begin miscompares++; $display("FAIL basic_frameerr got %b expected 0", cap_ferr[0]); end
        end
        vectors++; if (val_hi != 1) begin miscompares++; $display("FAIL basic_valid_width got %0d expected 1", val_hi); end
        vectors++; if (en_wide != 0) begin miscompares++; $display("FAIL basic_enable_width got %0d expected 0", en_wide); end
    endtask

    task automatic test_glitch();
        clear_mon();
        tick_cycles(1'b0, 4, 1'b0);
        idle(3*OS);
        vectors++; if (en_cyc.size() != 0) begin miscompares++; $display("FAIL glitch_enable got %0d expected 0", en_cyc.size()); end
        vectors++; if (val_cyc.size() != 0 || rx_if.Valid !== 1'b0) begin miscompares++; $display("FAIL glitch_valid got %0d expected 0", val_cyc.size()); end
    endtask

    task automatic test_frame_err();
        Ready_drv(1'b1);
        clear_mon();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        idle(OS);
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        idle(4);
        vectors++;
        if (val_cyc.size() != 2) begin
            miscompares++; $display("FAIL ferr_valid_count got %0d expected 2", val_cyc.size());
        end else begin
            vectors++; if (cap_data[0] !== 8'h3C) begin miscompares++; $display("FAIL ferr_data0 got %h expected 3c", cap_data[0]); end
            vectors++; if (cap_ferr[0] !== 1'b1) begin miscompares++; $display("FAIL ferr_flag0 got %b expected 1", cap_ferr[0]); end
            vectors++; if (cap_data[1] !== 8'h01) begin miscompares++; $display("FAIL ferr_data1 got %h expected 01", cap_data[1]); end
            vectors++; if (cap_ferr[1] !== 1'b0) begin miscompares++; $display("FAIL ferr_flag1 got %b expected 0", cap_ferr[1]); end
        end
        vectors++; if (rx_if.FrameErr !== 1'b0) begin miscompares++; $display("FAIL ferr_hold got %b expected 0", rx_if.FrameErr); end
    endtask

    task automatic test_overrun();
        Ready_drv(1'b0);
        clear_mon();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        idle(OS);
        vectors++; if (rx_if.Valid !== 1'b1 || rx_if.Overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_first got valid %b overrun %b expected 1 0", rx_if.Valid, rx_if.Overrun); end
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        idle(4);
        vectors++; if (rx_if.Data !== 8'h22) begin miscompares++; $display("FAIL ovr_data got %h expected 22", rx_if.Data); end
        vectors++; if (rx_if.Valid !== 1'b1) begin miscompares++; $display("FAIL ovr_valid got %b expected 1", rx_if.Valid); end
        vectors++; if (rx_if.Overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag got %b expected 1", rx_if.Overrun); end
        @(negedge Clock);
        Ready_drv(1'b1);
        @(negedge Clock);
        vectors++; if (rx_if.Valid !== 1'b0) begin miscompares++; $display("FAIL ovr_valid_clear got %b expected 0", rx_if.Valid); end
        vectors++; if (rx_if.Overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_flag_clear got %b expected 0", rx_if.Overrun); end
        vectors++; if (rx_if.Data !== 8'h22) begin miscompares++; $display("FAIL ovr_data_hold got %h expected 22", rx_if.Data); end
    endtask

    task automatic test_abort();
        logic [7:0] d;
        d = 8'h0F;
        Ready_drv(1'b1);
        clear_mon();
        tick_cycles(1'b0, OS, 1'b0);
        for (int i = 0; i < 4; i++) tick_cycles(d[i], OS, 1'b0);
        tick_cycles(d[4], OS/2, 1'b0);
        vectors++; if (en_cyc.size() != 4) begin miscompares++; $display("FAIL abort_enables got %0d expected 4", en_cyc.size()); end
        nReset = 1'b0;
        RxD = 1'b1;
        @(negedge Clock);
        vectors++; if (ShiftIn !== 1'b0 || Enable !== 1'b0) begin miscompares++; $display("FAIL abort_shift got %b%b expected 00", ShiftIn, Enable); end
        vectors++; if (rx_if.Data !== 8'h00 || rx_if.Valid !== 1'b0) begin miscompares++; $display("FAIL abort_data got %h/%b expected 00/0", rx_if.Data, rx_if.Valid); end
        vectors++; if (rx_if.FrameErr !== 1'b0 || rx_if.Overrun !== 1'b0) begin miscompares++; $display("FAIL abort_flags got %b%b expected 00", rx_if.FrameErr, rx_if.Overrun); end
        @(negedge Clock);
        nReset = 1'b1;
        idle(OS);
        clear_mon();
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        idle(4);
        vectors++; if (en_cyc.size() != 8 || bits_from(0) !== 8'h5A) begin miscompares++; $display("FAIL abort_next_shift got %0d/%h expected 8/5a", en_cyc.size(), bits_from(0)); end
        vectors++; if (cap_data.size() != 1 || cap_data[0] !== 8'h5A) begin miscompares++; $display("FAIL abort_next_data got %0d frames expected 1 with 5a", cap_data.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        Ready_drv(1'b1);
        clear_mon();
        for (int f = 0; f < 4; f++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1, ^b, 1'b0);
        end
        idle(4);
        vectors++;
        if (cap_data.size() != 4 || en_bits.size() != 32) begin
            miscompares++; $display("FAIL b2b_counts got %0d frames %0d enables expected 4 32", cap_data.size(), en_bits.size());
        end else begin
            for (int f = 0; f < 4; f++) begin
                vectors++; if (cap_data[f] !== exp_q[f] || cap_ferr[f] !== 1'b0) begin miscompares++; $display("FAIL b2b_data%0d got %h/%b expected %h/0", f, cap_data[f], cap_ferr[f], exp_q[f]); end
                vectors++; if (bits_from(8*f) !== exp_q[f]) begin miscompares++; $display("FAIL b2b_shift%0d got %h expected %h", f, bits_from(8*f), exp_q[f]); end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop, par, exp_perr;
        Ready_drv(1'b1);
        for (int f = 0; f < 12; f++) begin
            b = 8'($urandom);
            stop = 1'($urandom_range(0, 1));
            par = 1'($urandom_range(0, 1));
`ifdef SERIAL_RX_PARITY_EN
            exp_perr = (^b) ^ par;
`else
            exp_perr = 1'b0;
`endif
            clear_mon();
            send_frame(b, stop, par, 1'b1);
            idle(OS);
            vectors++;
            if (cap_data.size() != 1) begin
                miscompares++; $display("FAIL rand%0d_frames got %0d expected 1", f, cap_data.size());
            end else begin
                vectors++; if (cap_data[0] !== b) begin miscompares++; $display("FAIL rand%0d_data got %h expected %h", f, cap_data[0], b); end
                vectors++; if (cap_ferr[0] !== ~stop) begin miscompares++; $display("FAIL rand%0d_frameerr got %b expected %b", f, cap_ferr[0], ~stop); end
                vectors++; if (cap_perr[0] !== exp_perr) begin miscompares++; $display("FAIL rand%0d_parityerr got %b expected %b", f, cap_perr[0], exp_perr); end
            end
            vectors++; if (en_bits.size() != 8 || bits_from(0) !== b) begin miscompares++; $display("FAIL rand%0d_shift got %0d/%h expected 8/%h", f, en_bits.size(), bits_from(0), b); end
        end
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic test_parity();
        Ready_drv(1'b1);
        for (int p = 1; p >= 0; p--) begin
            clear_mon();
            send_frame(8'h07, 1'b1, 1'(p), 1'b0);
            idle(4);
            vectors++; if (en_bits.size() != 8) begin miscompares++; $display("FAIL parity%0d_enables got %0d expected 8", p, en_bits.size()); end
            vectors++; if (cap_perr.size() != 1 || cap_perr[0] !== 1'(1 - p)) begin miscompares++; $display("FAIL parity%0d_flag got %0d frames expected 1 with %0d", p, cap_perr.size(), 1 - p); end
        end
    endtask
`endif

    initial begin
        rx_if.Ready = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_abort();
        test_back_to_back();
        test_random();
`ifdef SERIAL_RX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
